pll_lock_sequencer: RTL

- Refclk-domain controller that sequences the audio PLL's reset and qualifies its lock output.
- Drives the PLL reset input and synchronises and debounces the asynchronous `locked` signal.
- Retries on lock timeout and declares a fault after repeated failures.
- Issues `clk_ready`, which gates all 768 kHz audio logic, and counts lock-loss events for software.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the audio PLL lock sequencer.
package pll_seq_pkg;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Lock-loss events are reported to software; the count sticks at all-ones.
    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the audio PLL reset, qualifies its lock output and raises
// clk_ready once lock has been stable; retries on timeout, faults after budget.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 20
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               clk_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0]  lock_loss_count,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic lk;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    pll_state_e         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               pll_rst_q,   pll_rst_d;
    logic               clk_ready_q, clk_ready_d;
    logic               fault_q,     fault_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic [LOSS_W-1:0]  loss_q,      loss_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pll_rst_d   = pll_rst_q;
        clk_ready_d = clk_ready_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        loss_d      = loss_q;

        if (restart) begin
            // Restart overrides everything, including a simultaneous lock loss.
            state_d     = RESET_PLL;
            cnt_d       = '0;
            pll_rst_d   = 1'b1;
            clk_ready_d = 1'b0;
            fault_d     = 1'b0;
            retry_d     = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d   = WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        if (retry_q == RETRY_MAX) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = RESET_PLL;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                STABLE: begin
                    // A dropout restarts the timeout window without costing a retry.
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d     = RUN;
                        cnt_d       = '0;
                        clk_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (!lk) begin
                        state_d     = RESET_PLL;
                        cnt_d       = '0;
                        clk_ready_d = 1'b0;
                        pll_rst_d   = 1'b1;
                        retry_d     = '0;
                        loss_d      = sat_inc_loss(loss_q);
                    end
                end

                FAULT: begin
                    pll_rst_d   = 1'b1;
                    fault_d     = 1'b1;
                    clk_ready_d = 1'b0;
                end

                default: begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    pll_rst_d   = 1'b1;
                    clk_ready_d = 1'b0;
                    fault_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            clk_ready_q <= clk_ready_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign clk_ready       = clk_ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state_dbg       = state_q;

endmodule
